// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch slice.
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;

  // One buffered fetch result: address and the word read from it.
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-side bus: InstructionMem port, redirect input and decode handshake.
interface fetch_controller_if;
  logic        im_en;
  logic [15:0] im_pc;
  logic [15:0] im_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        id_ready;
  logic        halted;

  modport master (
    output im_en, im_pc, instr_valid, instr, instr_pc, halted,
    input  im_instr, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  im_en, im_pc, instr_valid, instr, instr_pc, halted,
    output im_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO whose head entry is a register driven straight to decode.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         valid,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  // Next-state for head/tail/occupancy; flush wins over push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else if (push && pop) begin
      if (count_q == 2'd2) begin
        head_d = tail_q;
        tail_d = push_data;
      end else begin
        head_d = push_data;
      end
    end else if (pop) begin
      head_d  = tail_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) begin
        head_d = push_data;
      end else begin
        tail_d = push_data;
      end
      count_d = count_q + 2'd1;
    end
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign valid = (count_q != 2'd0);
  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: PC, boot/run/halt FSM, issue credit and response kill.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter int unsigned IM_LATENCY  = 1
) (
  input logic               clk,
  input logic               rst_n,
  fetch_controller_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  inflight_pc_q;
  logic         inflight_q;

  logic         issue, pop, push, kill, push_halt;
  logic         buf_valid;
  logic [1:0]   count;
  logic [2:0]   credit;
  fetch_entry_t head, push_data;

  assign pop       = buf_valid & bus.id_ready;
  // A response is dropped on redirect, or once a HALT has stopped the stream.
  assign kill      = bus.redirect_valid | (state_q == StHalted);
  assign push      = inflight_q & ~kill;
  assign push_data = '{pc: inflight_pc_q, instr: bus.im_instr};
  assign push_halt = push & (bus.im_instr[15:12] == HALT_OPCODE);

  // Slots still claimed after this cycle's pop: buffered words plus the outstanding read.
  assign credit = {1'b0, count} - {2'b0, pop} + {2'b0, inflight_q};
  // Only single-cycle memory is supported; any other latency keeps fetch idle.
  assign issue  = (state_q == StRun) & ~bus.redirect_valid & (credit < 3'd2) &
                  (IM_LATENCY == 1);

  // Next state and next PC; redirect overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      StBoot:   state_d = StRun;
      StRun:    if (push_halt) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StBoot;
    endcase
    if (issue) pc_d = pc_q + 16'd1;
    if (bus.redirect_valid) begin
      state_d = StRun;
      pc_d    = bus.redirect_pc;
    end
  end

  // PC, FSM and outstanding-read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
    end
  end

  fetch_buffer u_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .valid     (buf_valid),
    .head      (head),
    .count     (count)
  );

  assign bus.im_en       = issue;
  assign bus.im_pc       = pc_q;
  assign bus.instr_valid = buf_valid;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.halted      = (state_q == StHalted) & (count == 2'd0);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: queue-based reference model plus program-order stream check.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic rst_n;

  fetch_controller_if bus ();

  fetch_controller #(
    .RESET_PC    (16'h0000),
    .HALT_OPCODE (4'hF),
    .IM_LATENCY  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program image: word = address + 0x1000, with an optional HALT word at halt_pc.
  logic        halt_en;
  logic [15:0] halt_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (halt_en && a == halt_pc) return 16'hF000;
    w = a + 16'h1000;
    if (w[15:12] == 4'hF) w[15:12] = 4'hE;
    return w;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (bus.im_en) bus.im_instr <= mem_word(bus.im_pc);
  end

  // Reference model: buffer as a queue, one outstanding read, coarse run state.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        m_q[$];
  int          m_state;  // 0 boot, 1 run, 2 halted
  logic [15:0] m_pc;
  logic [15:0] m_infl_pc;
  bit          m_infl;

  // Program-order stream view of what decode accepted.
  logic [15:0] s_next;
  bit          s_halted;
  logic [15:0] acc_q[$];
  logic [15:0] last_pc, last_instr;

  always @(negedge clk) begin
    bit          e_valid, e_pop, e_en;
    int          occ;
    logic [15:0] w;
    if (!rst_n) begin
      check("rst_im_en", 32'(bus.im_en), 0);
      check("rst_instr_valid", 32'(bus.instr_valid), 0);
      check("rst_instr", 32'(bus.instr), 0);
      check("rst_instr_pc", 32'(bus.instr_pc), 0);
      check("rst_halted", 32'(bus.halted), 0);
      m_q.delete();
      m_state  = 0;
      m_pc     = 16'h0000;
      m_infl   = 1'b0;
      s_next   = 16'h0000;
      s_halted = 1'b0;
    end else begin
      occ     = m_q.size();
      e_valid = (occ > 0);
      e_pop   = e_valid && bus.id_ready;
      e_en    = (m_state == 1) && !bus.redirect_valid &&
                ((occ - int'(e_pop) + int'(m_infl)) < 2);
      check("im_en", 32'(bus.im_en), 32'(e_en));
      if (e_en) check("im_pc", 32'(bus.im_pc), 32'(m_pc));
      check("instr_valid", 32'(bus.instr_valid), 32'(e_valid));
      if (e_valid) begin
        check("instr", 32'(bus.instr), 32'(m_q[0].instr));
        check("instr_pc", 32'(bus.instr_pc), 32'(m_q[0].pc));
      end
      check("halted", 32'(bus.halted), 32'((m_state == 2) && (occ == 0)));

      if (bus.instr_valid && bus.id_ready) begin
        check("stream_pc", 32'(bus.instr_pc), 32'(s_next));
        check("stream_instr", 32'(bus.instr), 32'(mem_word(bus.instr_pc)));
        check("stream_after_halt", 32'(s_halted), 0);
        acc_q.push_back(bus.instr_pc);
        last_pc    = bus.instr_pc;
        last_instr = bus.instr;
        s_next     = bus.instr_pc + 16'd1;
        if (bus.instr[15:12] == 4'hF) s_halted = 1'b1;
      end

      if (e_pop) m_q.delete(0);
      if (bus.redirect_valid) begin
        m_q.delete();
        m_infl   = 1'b0;
        m_pc     = bus.redirect_pc;
        m_state  = 1;
        s_next   = bus.redirect_pc;
        s_halted = 1'b0;
      end else begin
        if (m_infl && m_state != 2) begin
          w = mem_word(m_infl_pc);
          m_q.push_back('{pc: m_infl_pc, instr: w});
          if (w[15:12] == 4'hF) m_state = 2;
        end
        if (m_state == 0) m_state = 1;
        m_infl = e_en;
        if (e_en) begin
          m_infl_pc = m_pc;
          m_pc      = m_pc + 16'd1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (acc_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(acc_q.size() >= n), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n              = 1'b0;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    halt_en            = 1'b0;
    halt_pc            = 16'h0005;
    repeat (3) cyc();
    cyc();
    rst_n = 1'b1;

    // Boot and streaming latency.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) check("boot_no_issue", 32'(bus.im_en), 0);
      if (c == 1) begin
        check("first_issue_en", 32'(bus.im_en), 1);
        check("first_issue_pc", 32'(bus.im_pc), 32'h0000);
      end
      if (c == 2) check("second_issue_pc", 32'(bus.im_pc), 32'h0001);
      if (c == 3) begin
        check("first_valid", 32'(bus.instr_valid), 1);
        check("first_instr_pc", 32'(bus.instr_pc), 32'h0000);
        check("first_instr", 32'(bus.instr), 32'h1000);
      end
      if (c == 4) begin
        check("second_instr_pc", 32'(bus.instr_pc), 32'h0001);
        check("second_instr", 32'(bus.instr), 32'h1001);
      end
    end

    // Decode stall: buffer fills, fetch stops.
    cyc();
    bus.id_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_no_issue", 32'(bus.im_en), 0);
      check("stall_valid", 32'(bus.instr_valid), 1);
      cyc();
    end
    bus.id_ready = 1'b1;
    repeat (6) cyc();

    // Redirect to 0x0040.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0040;
    @(negedge clk);
    check("redir_no_issue", 32'(bus.im_en), 0);
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_flushed", 32'(bus.instr_valid), 0);
    check("redir_issue_en", 32'(bus.im_en), 1);
    check("redir_issue_pc", 32'(bus.im_pc), 32'h0040);
    cyc();
    cyc();
    @(negedge clk);
    check("redir_first_valid", 32'(bus.instr_valid), 1);
    check("redir_first_pc", 32'(bus.instr_pc), 32'h0040);
    repeat (4) cyc();

    // HALT at pc 5, then resume at 0x0010.
    rst_n   = 1'b0;
    halt_en = 1'b1;
    cyc();
    cyc();
    acc_q.delete();
    rst_n = 1'b1;
    n = 0;
    while (!bus.halted && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", 32'(bus.halted), 1);
    check("halt_last_pc", 32'(last_pc), 32'h0005);
    check("halt_last_instr", 32'(last_instr), 32'hF000);
    check("halt_accept_count", 32'(acc_q.size()), 6);
    repeat (5) cyc();
    @(negedge clk);
    check("halt_holds_pc", 32'(last_pc), 32'h0005);
    check("halt_holds_flag", 32'(bus.halted), 1);
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0010;
    cyc();
    bus.redirect_valid = 1'b0;
    acc_q.delete();
    wait_accepts(1, 20, "resume_accept");
    if (acc_q.size() > 0) check("resume_pc", 32'(acc_q[0]), 32'h0010);

    // Wrap at the top of the address space.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFE;
    cyc();
    bus.redirect_valid = 1'b0;
    acc_q.delete();
    wait_accepts(4, 30, "wrap_accepts");
    if (acc_q.size() >= 4) begin
      check("wrap_pc0", 32'(acc_q[0]), 32'hFFFE);
      check("wrap_pc1", 32'(acc_q[1]), 32'hFFFF);
      check("wrap_pc2", 32'(acc_q[2]), 32'h0000);
      check("wrap_pc3", 32'(acc_q[3]), 32'h0001);
    end

    // Asynchronous reset with a full buffer.
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0020;
    cyc();
    bus.redirect_valid = 1'b0;
    repeat (3) cyc();
    bus.id_ready = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("prereset_full", 32'(bus.instr_valid), 1);
    cyc();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.instr_valid), 0);
    check("async_rst_instr_pc", 32'(bus.instr_pc), 0);
    cyc();
    bus.id_ready = 1'b1;
    cyc();
    acc_q.delete();
    rst_n = 1'b1;
    wait_accepts(1, 20, "restart_accept");
    if (acc_q.size() > 0) check("restart_pc", 32'(acc_q[0]), 32'h0000);

    // Random traffic: stalls, redirects near zero and near the wrap point.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) bus.redirect_pc = 16'hFFF8 + 16'($urandom_range(0, 15));
      else                           bus.redirect_pc = 16'($urandom_range(0, 40));
    end
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
